// File: rtl/key_debounce_if.sv
// Key debouncer interface: raw key level and glitch clear in; debounced level,
// busy flag and saturating glitch count out.
interface key_debounce_if;
  localparam int unsigned GCNT_W = 8;

  logic              data_in;
  logic              glitch_clr;
  logic              data_out;
  logic              busy;
  logic [GCNT_W-1:0] glitch_cnt;

  modport master (
    output data_in,
    output glitch_clr,
    input  data_out,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  data_in,
    input  glitch_clr,
    output data_out,
    output busy,
    output glitch_cnt
  );
endinterface

// File: rtl/key_debounce.sv
// Key/switch debouncer: two-flop synchronizer feeding a four-state qualifier
// that only accepts a new level after DEBOUNCE_CYC+1 consecutive stable samples.
module key_debounce #(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter logic        RST_LEVEL    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  dbus
);

  localparam int unsigned GCNT_W = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [GCNT_W-1:0] GCNT_MAX  = {GCNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam state_t RST_STATE = RST_LEVEL ? ST_HI : ST_LO;

  logic              r_s1;
  logic              r_s2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_data_out;
  logic              r_busy;
  logic [GCNT_W-1:0] r_glitch_cnt;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_glitch;

  // Synchronizer for the asynchronous key input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= RST_LEVEL;
      r_s2 <= RST_LEVEL;
    end else begin
      r_s1 <= dbus.data_in;
      r_s2 <= r_s1;
    end
  end

  // Next-state logic; a glitch is a return to the old level mid-qualification
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_glitch    = 1'b0;
    case (r_state)
      ST_LO: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = ST_LO;
          w_glitch    = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HI;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = ST_HI;
          w_glitch    = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // State register; data_out and busy are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_cnt      <= '0;
      r_data_out <= RST_LEVEL;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data_out <= (w_state_nxt == ST_HI) || (w_state_nxt == WAIT_LO);
      r_busy     <= (w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO);
    end
  end

  // Saturating glitch counter; clear wins over a coincident glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch_cnt <= '0;
    end else if (dbus.glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != GCNT_MAX)) begin
      r_glitch_cnt <= r_glitch_cnt + GCNT_W'(1);
    end
  end

  assign dbus.data_out   = r_data_out;
  assign dbus.busy       = r_busy;
  assign dbus.glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_key_debounce;

  localparam int DC = 8;

  typedef struct packed {
    logic       out;
    logic       busy;
    logic [7:0] gcnt;
  } exp_t;

  logic clk;
  logic rst;
  key_debounce_if bus ();

  key_debounce #(
    .CNT_W       (4),
    .DEBOUNCE_CYC(DC),
    .RST_LEVEL   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dbus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: samples reach the qualifier two edges late; the output
  // flips once DC+1 consecutive samples disagree with it.
  logic       m_d1   = 1'b0;
  logic       m_d2   = 1'b0;
  logic       m_out  = 1'b0;
  int         m_run  = 0;
  logic [7:0] m_gcnt = 8'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic din, input logic clr, input logic r);
    logic s;
    logic glitch;
    exp_t e;
    bus.data_in    = din;
    bus.glitch_clr = clr;
    rst            = r;
    glitch         = 1'b0;
    if (r) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_out = 1'b0; m_run = 0; m_gcnt = 8'd0;
    end else begin
      s    = m_d2;
      m_d2 = m_d1;
      m_d1 = din;
      if (s != m_out) begin
        m_run++;
        if (m_run == DC + 1) begin
          m_out = s;
          m_run = 0;
        end
      end else if (m_run > 0) begin
        glitch = 1'b1;
        m_run  = 0;
      end
      if (clr)                          m_gcnt = 8'd0;
      else if (glitch && m_gcnt != 8'd255) m_gcnt = m_gcnt + 8'd1;
    end
    e.out  = m_out;
    e.busy = (m_run > 0);
    e.gcnt = m_gcnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic din, input int n);
    for (int i = 0; i < n; i++) step(din, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("data_out",   {7'd0, bus.data_out}, {7'd0, e.out});
        chk("busy",       {7'd0, bus.busy},     {7'd0, e.busy});
        chk("glitch_cnt", bus.glitch_cnt,       e.gcnt);
      end
    end
  end

  initial begin
    bus.data_in    = 1'b0;
    bus.glitch_clr = 1'b0;
    rst            = 1'b1;

    // Reset and idle low
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    hold(1'b0, 5);

    // Clean rise then clean fall
    hold(1'b1, 14);
    hold(1'b0, 14);

    // Bounce 1,0,1,1,0 then stable high, then back low
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    hold(1'b1, 14);
    hold(1'b0, 14);

    // Eight samples high is one short; nine qualifies
    hold(1'b1, 8);
    hold(1'b0, 12);
    hold(1'b1, 9);
    hold(1'b0, 14);

    // Saturation with 300 single-sample pulses
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    hold(1'b0, 4);
    chk("glitch_sat", bus.glitch_cnt, 8'd255);

    // Clear coincident with a glitch event
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("glitch_clr_prio", bus.glitch_cnt, 8'd0);
    hold(1'b0, 4);

    // Reset in the middle of qualifying a rise, key held high throughout
    hold(1'b1, 8);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 12);
    hold(1'b0, 14);

    // Random bursts with occasional clear and reset
    for (int b = 0; b < 150; b++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++)
        step(lvl, 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 299) == 0));
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
